// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: two per-requester FIFOs drained round-robin into one LCD controller.
// Optional lock feature (macro LCD_LOCK_EN) pins arbitration to a requester across bytes.
module lcd_cmd_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned HOLDOFF  = 2,
  parameter int unsigned LOCK_TMO = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
`ifdef LCD_LOCK_EN
  input  logic       req0_lock,
  input  logic       req1_lock,
`endif
  output logic       lcd_rs_sel,
  output logic       lcd_rw_sel,
  output logic [7:0] lcd_data,
  output logic       lcd_execute,
  input  logic       lcd_is_ready,
  output logic       grant,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
`ifdef LCD_LOCK_EN
  localparam int unsigned EW = 10;
  localparam int unsigned TW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;
`else
  localparam int unsigned EW = 9;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;

  state_t              state_q;
  logic                exec_q, rs_q, grant_q, busy_q, rr_q;
  logic [7:0]          data_q;
  logic [HW-1:0]       hold_q;
  logic [1:0]          req_valid, push, pop, full, empty;
  logic [1:0][EW-1:0]  wdata, head;
  logic                pick_ok, pick_idx, take;
  logic [EW-1:0]       head_sel;
`ifdef LCD_LOCK_EN
  logic                pin_q, pin_idx_q;
  logic [TW-1:0]       tmo_q;

  assign wdata[0] = {req0_lock, req0_rs, req0_data};
  assign wdata[1] = {req1_lock, req1_rs, req1_data};
`else
  assign wdata[0] = {req0_rs, req0_data};
  assign wdata[1] = {req1_rs, req1_data};
`endif

  assign req_valid  = {req1_valid, req0_valid};
  assign req0_ready = ~full[0];
  assign req1_ready = ~full[1];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;

    // Full/ready come from registered pointers only: a same-cycle pop never frees a slot early.
    assign empty[g] = (wptr_q == rptr_q);
    assign full[g]  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push[g]  = req_valid[g] & ~full[g];
    assign head[g]  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wptr_q[AW-1:0]] <= wdata[g];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push[g]) wptr_q <= wptr_q + 1'b1;
        if (pop[g])  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = 1'b0;
    if (~empty[0] & ~empty[1]) begin
      pick_ok  = 1'b1;
      pick_idx = rr_q;
    end else if (~empty[0]) begin
      pick_ok  = 1'b1;
      pick_idx = 1'b0;
    end else if (~empty[1]) begin
      pick_ok  = 1'b1;
      pick_idx = 1'b1;
    end
`ifdef LCD_LOCK_EN
    // A pinned requester overrides round robin; nothing issues while its FIFO is empty.
    if (pin_q) begin
      pick_ok  = ~empty[pin_idx_q];
      pick_idx = pin_idx_q;
    end
`endif
    take     = (state_q == S_IDLE) && lcd_is_ready && pick_ok;
    pop      = '0;
    pop[pick_idx] = take;
    head_sel = head[pick_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      exec_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      rr_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      exec_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (take) begin
          rs_q    <= head_sel[8];
          data_q  <= head_sel[7:0];
          grant_q <= pick_idx;
          rr_q    <= ~pick_idx;
          exec_q  <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          hold_q  <= '0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_q == HW'(HOLDOFF - 1)) state_q <= S_WAIT;
          else                            hold_q  <= hold_q + 1'b1;
        end
        S_WAIT: if (lcd_is_ready) begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef LCD_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q     <= 1'b0;
      pin_idx_q <= 1'b0;
      tmo_q     <= '0;
    end else if (take) begin
      pin_q     <= head_sel[9];
      pin_idx_q <= pick_idx;
      tmo_q     <= '0;
    end else if (pin_q && (state_q == S_IDLE) && empty[pin_idx_q]) begin
      if (tmo_q == TW'(LOCK_TMO - 1)) begin
        pin_q <= 1'b0;
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end
`endif

  assign lcd_rs_sel  = rs_q;
  assign lcd_rw_sel  = 1'b0;
  assign lcd_data    = data_q;
  assign lcd_execute = exec_q;
  assign grant       = grant_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Self-checking bench for lcd_cmd_arbiter: directed scenarios plus a randomized run
// checked against a queue-based model of the arbitration rules.
module tb_lcd_cmd_arbiter;
  localparam int DEPTH    = 4;
  localparam int HOLDOFF  = 2;
  localparam int LOCK_TMO = 64;

  logic       clk = 1'b0, rst = 1'b1;
  logic       req0_valid = 0, req0_rs = 0, req1_valid = 0, req1_rs = 0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       lcd_rs_sel, lcd_rw_sel, lcd_execute, grant, busy;
  logic [7:0] lcd_data;
  logic       lcd_is_ready = 1'b0;
`ifdef LCD_LOCK_EN
  logic       req0_lock = 1'b0, req1_lock = 1'b0;
`endif

  int n_checks = 0, n_fail = 0;
  int cyc = 0;

  typedef struct { logic [8:0] d; int ts; } ent_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_cmd_arbiter #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .LOCK_TMO(LOCK_TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
`ifdef LCD_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .lcd_rs_sel(lcd_rs_sel), .lcd_rw_sel(lcd_rw_sel), .lcd_data(lcd_data),
    .lcd_execute(lcd_execute), .lcd_is_ready(lcd_is_ready),
    .grant(grant), .busy(busy)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 0; req1_valid = 0; lcd_is_ready = 0;
`ifdef LCD_LOCK_EN
    req0_lock = 0; req1_lock = 0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int nexec;
    apply_reset();
    lcd_is_ready = 1; req1_valid = 1; req1_rs = 1; req1_data = 8'hFF;
    @(negedge clk); req1_valid = 0;
    @(negedge clk); lcd_is_ready = 0;
    if (lcd_execute !== 1'b1) begin n_fail++; $display("FAIL reset_pre_exec: got %b want 1", lcd_execute); end n_checks++;
    req0_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin req0_data = 8'(8'h60 + i); @(negedge clk); end
    req0_valid = 0;
    if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pre_full: got %b want 0", req0_ready); end n_checks++;
    rst = 1'b1; #1;
    if (lcd_execute !== 1'b0) begin n_fail++; $display("FAIL reset_execute: got %b want 0", lcd_execute); end n_checks++;
    if (lcd_rs_sel !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b want 0", lcd_rs_sel); end n_checks++;
    if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", lcd_data); end n_checks++;
    if (grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end n_checks++;
    if (lcd_rw_sel !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b want 0", lcd_rw_sel); end n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b%b want 11", req1_ready, req0_ready); end n_checks++;
    @(negedge clk); rst = 1'b0; lcd_is_ready = 1;
    nexec = 0;
    repeat (12) begin @(negedge clk); if (lcd_execute === 1'b1) nexec++; end
    if (nexec != 0) begin n_fail++; $display("FAIL reset_flush: got %0d executes want 0", nexec); end n_checks++;
  endtask

  task automatic test_single();
    apply_reset();
    lcd_is_ready = 1; req0_valid = 1; req0_rs = 1; req0_data = 8'h41;
    @(negedge clk); req0_valid = 0;
    if (lcd_execute !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", lcd_execute); end n_checks++;
    @(negedge clk);
    if (lcd_execute !== 1'b1) begin n_fail++; $display("FAIL single_exec: got %b want 1", lcd_execute); end n_checks++;
    if (lcd_data !== 8'h41 || lcd_rs_sel !== 1'b1 || grant !== 1'b0)
      begin n_fail++; $display("FAIL single_payload: got rs=%b data=%h grant=%b want rs=1 data=41 grant=0", lcd_rs_sel, lcd_data, grant); end
    n_checks++;
    @(negedge clk);
    if (lcd_execute !== 1'b0 || lcd_data !== 8'h41) begin n_fail++; $display("FAIL single_pulse: got exec=%b data=%h want exec=0 data=41", lcd_execute, lcd_data); end n_checks++;
    repeat (4) @(negedge clk);
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b want 0", busy); end n_checks++;
  endtask

  task automatic test_rr_order();
    logic [7:0] exp_d [4];
    logic       exp_g [4];
    int got, busyc;
    exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    req0_valid = 1; req0_rs = 0; req0_data = 8'h10; req1_valid = 1; req1_rs = 1; req1_data = 8'h20;
    @(negedge clk); req0_data = 8'h11; req1_data = 8'h21;
    @(negedge clk); req0_valid = 0; req1_valid = 0; lcd_is_ready = 1;
    got = 0; busyc = 0;
    for (int i = 0; i < 200 && got < 4; i++) begin
      @(negedge clk);
      if (lcd_execute === 1'b1) begin
        if (lcd_data !== exp_d[got] || grant !== exp_g[got])
          begin n_fail++; $display("FAIL rr_order[%0d]: got data=%h grant=%b want data=%h grant=%b", got, lcd_data, grant, exp_d[got], exp_g[got]); end
        n_checks++;
        got++; busyc = 5;
      end
      lcd_is_ready = (busyc == 0);
      if (busyc > 0) busyc--;
    end
    if (got != 4) begin n_fail++; $display("FAIL rr_count: got %0d executes want 4", got); end n_checks++;
  endtask

  task automatic test_full();
    int got;
    apply_reset();
    req0_valid = 1; req0_rs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d: got %b want 1", i, req0_ready); end n_checks++;
      req0_data = 8'(8'h30 + i);
      @(negedge clk);
    end
    req0_data = 8'h34;
    if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_after: got %b want 0", req0_ready); end n_checks++;
    repeat (2) @(negedge clk);
    if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_held: got %b want 0", req0_ready); end n_checks++;
    req0_valid = 0; lcd_is_ready = 1;
    got = 0;
    repeat (60) begin
      @(negedge clk);
      if (lcd_execute === 1'b1) begin
        if (got < DEPTH && lcd_data !== 8'(8'h30 + got))
          begin n_fail++; $display("FAIL full_drain[%0d]: got %h want %h", got, lcd_data, 8'(8'h30 + got)); end
        if (got < DEPTH) n_checks++;
        got++;
      end
    end
    if (got != DEPTH) begin n_fail++; $display("FAIL full_count: got %0d want %0d", got, DEPTH); end n_checks++;
    if (req0_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL full_end: got ready=%b busy=%b want 1 0", req0_ready, busy); end n_checks++;
  endtask

  task automatic test_reset_mid();
    int nexec;
    bit seen;
    apply_reset();
    lcd_is_ready = 1; req0_valid = 1; req0_rs = 1;
    for (int i = 0; i < 3; i++) begin req0_data = 8'(8'hA0 + i); @(negedge clk); end
    req0_valid = 0;
    seen = (lcd_execute === 1'b1);
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = (lcd_execute === 1'b1); end
    if (!seen) begin n_fail++; $display("FAIL rstmid_exec: got no execute want one"); end n_checks++;
    @(negedge clk);
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_hold: got busy=%b want 1", busy); end n_checks++;
    rst = 1'b1; #1;
    if (busy !== 1'b0 || lcd_execute !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got busy=%b exec=%b want 0 0", busy, lcd_execute); end n_checks++;
    @(negedge clk); rst = 1'b0;
    nexec = 0;
    repeat (30) begin @(negedge clk); if (lcd_execute === 1'b1) nexec++; end
    if (nexec != 0) begin n_fail++; $display("FAIL rstmid_flush: got %0d executes want 0", nexec); end n_checks++;
  endtask

  task automatic test_wait();
    int nexec;
    apply_reset();
    lcd_is_ready = 1; req0_valid = 1; req0_rs = 0; req0_data = 8'h50;
    @(negedge clk); req0_data = 8'h51;
    @(negedge clk); req0_valid = 0; lcd_is_ready = 0;
    if (lcd_execute !== 1'b1 || lcd_data !== 8'h50) begin n_fail++; $display("FAIL wait_first: got exec=%b data=%h want 1 50", lcd_execute, lcd_data); end n_checks++;
    nexec = 0;
    repeat (20) begin @(negedge clk); if (lcd_execute === 1'b1) nexec++; end
    if (nexec != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL wait_stall: got execs=%0d busy=%b want 0 1", nexec, busy); end n_checks++;
    lcd_is_ready = 1;
    @(negedge clk);
    if (lcd_execute !== 1'b0) begin n_fail++; $display("FAIL wait_idle: got exec=%b want 0", lcd_execute); end n_checks++;
    @(negedge clk);
    if (lcd_execute !== 1'b1 || lcd_data !== 8'h51) begin n_fail++; $display("FAIL wait_resume: got exec=%b data=%h want 1 51", lcd_execute, lcd_data); end n_checks++;
    repeat (6) @(negedge clk);
  endtask

`ifdef LCD_LOCK_EN
  task automatic test_lock(input int gap, input logic [7:0] exp1, input logic [7:0] exp2);
    logic [7:0] seen [3];
    int got, c0;
    apply_reset();
    lcd_is_ready = 1;
    req0_valid = 1; req0_lock = 1; req0_rs = 0; req0_data = 8'h80;
    req1_valid = 1; req1_lock = 0; req1_rs = 1; req1_data = 8'h20;
    @(negedge clk); req0_valid = 0; req1_valid = 0; req0_lock = 0;
    got = 0; c0 = 0;
    for (int k = 0; k < 400 && got < 3; k++) begin
      @(negedge clk);
      if (lcd_execute === 1'b1) begin seen[got] = lcd_data; if (got == 0) c0 = k; got++; end
      req0_valid = (got > 0) && (k - c0 == gap);
      req0_rs = 1; req0_data = 8'h41;
    end
    req0_valid = 0;
    if (got != 3) begin n_fail++; $display("FAIL lock%0d_count: got %0d want 3", gap, got); end
    else if (seen[0] !== 8'h80 || seen[1] !== exp1 || seen[2] !== exp2)
      begin n_fail++; $display("FAIL lock%0d_order: got %h %h %h want 80 %h %h", gap, seen[0], seen[1], seen[2], exp1, exp2); end
    n_checks++;
  endtask
`endif

  task automatic test_random();
    ent_t q0 [$], q1 [$];
    ent_t e;
    int   k, wait_start, ctrl_busy;
    bit   m_idle, pend, pend_idx, rr, r, e0, e1, v;
    logic [8:0] pay;
    m_idle = 1; pend = 0; pend_idx = 0; rr = 0; ctrl_busy = 0; wait_start = 0;
    apply_reset();
    for (int it = 0; it < 2000; it++) begin
      @(negedge clk);
      k = cyc;
      if (lcd_execute !== pend) begin n_fail++; $display("FAIL rnd_exec@%0d: got %b want %b", k, lcd_execute, pend); end n_checks++;
      if (pend) begin
        e = pend_idx ? q1.pop_front() : q0.pop_front();
        if (grant !== pend_idx || {lcd_rs_sel, lcd_data} !== e.d)
          begin n_fail++; $display("FAIL rnd_payload@%0d: got grant=%b rsdata=%h want %b %h", k, grant, {lcd_rs_sel, lcd_data}, pend_idx, e.d); end
        n_checks++;
        m_idle = 0; wait_start = k + HOLDOFF + 1;
        ctrl_busy = $urandom_range(0, 6);
      end
      pend = 0;
      if (busy !== !m_idle) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", k, busy, !m_idle); end n_checks++;
      if (req0_ready !== (q0.size() < DEPTH) || req1_ready !== (q1.size() < DEPTH))
        begin n_fail++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", k, req1_ready, req0_ready, q1.size() < DEPTH, q0.size() < DEPTH); end
      n_checks++;
      r = (ctrl_busy == 0) && ($urandom_range(0, 3) != 0);
      if (ctrl_busy > 0) ctrl_busy--;
      lcd_is_ready = r;
      if (m_idle) begin
        e0 = (q0.size() > 0) && (q0[0].ts <= k - 1);
        e1 = (q1.size() > 0) && (q1[0].ts <= k - 1);
        if (r && (e0 || e1)) begin
          pend = 1; pend_idx = (e0 && e1) ? rr : e1; rr = !pend_idx;
        end
      end else if (k >= wait_start && r) begin
        m_idle = 1;
      end
      v = (it < 1700) && ($urandom_range(0, 2) == 0);
      pay = 9'($urandom);
      req0_valid = v; {req0_rs, req0_data} = pay;
      if (v && q0.size() < DEPTH) begin e.d = pay; e.ts = k; q0.push_back(e); end
      v = (it < 1700) && ($urandom_range(0, 2) == 0);
      pay = 9'($urandom);
      req1_valid = v; {req1_rs, req1_data} = pay;
      if (v && q1.size() < DEPTH) begin e.d = pay; e.ts = k; q1.push_back(e); end
    end
    req0_valid = 0; req1_valid = 0;
    if (q0.size() + q1.size() != 0) begin n_fail++; $display("FAIL rnd_drained: got %0d left want 0", q0.size() + q1.size()); end n_checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_full();
    test_reset_mid();
    test_wait();
`ifdef LCD_LOCK_EN
    test_lock(10, 8'h41, 8'h20);
    test_lock(70, 8'h20, 8'h41);
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
